// File: rtl/pmod_btnled_ctrl.sv
// PMOD button/LED glue: per-channel synchronise, debounce and press-event capture
// with maskable IRQ, plus per-channel LED drive (static, blink, PWM, follow-button).
module pmod_btnled_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int DEBOUNCE   = 16,
  parameter int DBW        = 16,
  parameter int BLINK_BITS = 24,
  parameter int PWM_BITS   = 8
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic [CHANNELS-1:0]   BTN_RAW,
  output logic [CHANNELS-1:0]   BTN_LVL,
  output logic [CHANNELS-1:0]   BTN_EVT,
  input  logic [CHANNELS-1:0]   EVT_CLR,
  input  logic [CHANNELS-1:0]   IRQ_EN,
  output logic                  IRQ,
  input  logic [CHANNELS-1:0]   LED_VAL,
  input  logic [2*CHANNELS-1:0] LED_MODE,
  input  logic [PWM_BITS-1:0]   LED_DUTY,
  output logic [CHANNELS-1:0]   LED_OUT
);

  localparam logic [DBW-1:0] TERM = DBW'(DEBOUNCE - 1);

  logic [CHANNELS-1:0]   r_s1, r_s2, r_lvl, r_evt, r_led;
  logic                  r_irq;
  logic [DBW-1:0]        r_cnt [CHANNELS];
  logic [BLINK_BITS-1:0] r_blink;
  logic [PWM_BITS-1:0]   r_pwm;

  logic [DBW-1:0]        w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0]   w_lvl_nxt, w_evt_nxt, w_led_nxt;
  logic                  w_blink, w_pwm;

  // Counter only runs while the synchronised input disagrees with the level,
  // so any bounce back to the current level restarts qualification.
  always_comb begin
    w_lvl_nxt = r_lvl;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_lvl[i]) begin
        if (r_cnt[i] == TERM) w_lvl_nxt[i] = r_s2[i];
        else                  w_cnt_nxt[i] = r_cnt[i] + DBW'(1);
      end
    end
  end

  // A press arriving with its clear strobe still wins.
  assign w_evt_nxt = (w_lvl_nxt & ~r_lvl) | (r_evt & ~EVT_CLR);
  assign w_blink   = r_blink[BLINK_BITS-1];
  assign w_pwm     = (r_pwm < LED_DUTY);

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (LED_MODE[2*i +: 2])
        2'b00:   w_led_nxt[i] = LED_VAL[i];
        2'b01:   w_led_nxt[i] = LED_VAL[i] & w_blink;
        2'b10:   w_led_nxt[i] = LED_VAL[i] & w_pwm;
        default: w_led_nxt[i] = r_lvl[i];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_lvl   <= '0;
      r_evt   <= '0;
      r_led   <= '0;
      r_irq   <= 1'b0;
      r_blink <= '0;
      r_pwm   <= '0;
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= BTN_RAW;
      r_s2    <= r_s1;
      r_lvl   <= w_lvl_nxt;
      r_evt   <= w_evt_nxt;
      r_led   <= w_led_nxt;
      r_irq   <= |(w_evt_nxt & IRQ_EN);
      r_blink <= r_blink + BLINK_BITS'(1);
      r_pwm   <= r_pwm + PWM_BITS'(1);
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign BTN_LVL = r_lvl;
  assign BTN_EVT = r_evt;
  assign IRQ     = r_irq;
  assign LED_OUT = r_led;

endmodule

// File: tb/tb_pmod_btnled_ctrl.sv
// Bench for pmod_btnled_ctrl: directed scenarios plus randomized traffic
// compared against a window-based behavioural model.
module tb_pmod_btnled_ctrl;
  localparam int CH = 4, DB = 4, BB = 3, PB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_raw = '0, evt_clr = '0, irq_en = '0, led_val = '0;
  logic [2*CH-1:0] led_mode = '0;
  logic [PB-1:0] led_duty = '0;
  logic [CH-1:0] btn_lvl, btn_evt, led_out;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmod_btnled_ctrl #(
    .CHANNELS(CH), .DEBOUNCE(DB), .DBW(16), .BLINK_BITS(BB), .PWM_BITS(PB)
  ) dut (
    .CLK(clk), .RES(rst), .BTN_RAW(btn_raw), .BTN_LVL(btn_lvl), .BTN_EVT(btn_evt),
    .EVT_CLR(evt_clr), .IRQ_EN(irq_en), .IRQ(irq), .LED_VAL(led_val),
    .LED_MODE(led_mode), .LED_DUTY(led_duty), .LED_OUT(led_out)
  );

  // Reference: the level flips once the synchronised input (raw delayed two
  // samples) has disagreed with it for DB consecutive edges since the last flip.
  logic [CH-1:0] m_lvl, m_evt, m_led;
  logic          m_irq;
  logic [CH-1:0] raw_q[$];
  logic [CH-1:0] s2_q[$];
  int            since_flip[CH];
  int            cyc;

  always @(posedge clk or posedge rst) begin
    logic [CH-1:0] s2_used, new_lvl;
    logic          blink, pwm, ok;
    if (rst) begin
      m_lvl = '0; m_evt = '0; m_led = '0; m_irq = 1'b0; cyc = 0;
      raw_q.delete(); s2_q.delete();
      for (int i = 0; i < CH; i++) since_flip[i] = 0;
    end else begin
      s2_used = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
      raw_q.push_back(btn_raw);
      s2_q.push_back(s2_used);
      if (raw_q.size() > 8) void'(raw_q.pop_front());
      if (s2_q.size() > 8)  void'(s2_q.pop_front());
      new_lvl = m_lvl;
      for (int i = 0; i < CH; i++) begin
        since_flip[i]++;
        if (since_flip[i] >= DB && s2_q.size() >= DB) begin
          ok = 1'b1;
          for (int j = 1; j <= DB; j++)
            if (s2_q[s2_q.size()-j][i] == m_lvl[i]) ok = 1'b0;
          if (ok) begin
            new_lvl[i] = ~m_lvl[i];
            since_flip[i] = 0;
          end
        end
      end
      blink = ((cyc % 8) >= 4);
      pwm   = ((cyc % 8) < int'(led_duty));
      for (int i = 0; i < CH; i++) begin
        case (led_mode[2*i +: 2])
          2'b00:   m_led[i] = led_val[i];
          2'b01:   m_led[i] = led_val[i] & blink;
          2'b10:   m_led[i] = led_val[i] & pwm;
          default: m_led[i] = m_lvl[i];
        endcase
      end
      m_evt = (new_lvl & ~m_lvl) | (m_evt & ~evt_clr);
      m_irq = |(m_evt & irq_en);
      m_lvl = new_lvl;
      cyc++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_raw = '0; evt_clr = '0; irq_en = '0; led_val = '0; led_mode = '0; led_duty = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({btn_lvl, btn_evt, irq, led_out} !== '0) begin
      errors++;
      $display("FAIL reset_state got lvl=%b evt=%b irq=%b led=%b want all 0",
               btn_lvl, btn_evt, irq, led_out);
    end
  endtask

  task automatic test_debounce_timing(input logic [CH-1:0] en);
    logic exp_irq;
    do_reset();
    irq_en  = en;
    btn_raw = 4'b0001;
    exp_irq = en[0];
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) begin
        checks++;
        if ({btn_lvl, btn_evt, irq} !== 9'b0) begin
          errors++;
          $display("FAIL deb_edge5 got lvl=%b evt=%b irq=%b want 0000 0000 0", btn_lvl, btn_evt, irq);
        end
      end
      if (e == 6) begin
        checks++;
        if (btn_lvl !== 4'b0001 || btn_evt !== 4'b0001) begin
          errors++;
          $display("FAIL deb_edge6 got lvl=%b evt=%b want 0001 0001", btn_lvl, btn_evt);
        end
        checks++;
        if (irq !== exp_irq) begin
          errors++;
          $display("FAIL deb_irq en=%b got %b want %b", en, irq, exp_irq);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int rises, rise_edge;
    logic prev;
    do_reset();
    btn_raw = 4'b0001;
    repeat (2) @(negedge clk);
    btn_raw = 4'b0000;
    repeat (2) @(negedge clk);
    btn_raw = 4'b0001;
    rises = 0; rise_edge = -1; prev = btn_lvl[0];
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (btn_lvl[0] && !prev) begin
        rises++;
        rise_edge = e;
      end
      prev = btn_lvl[0];
    end
    checks++;
    if (rises !== 1 || rise_edge !== 6) begin
      errors++;
      $display("FAIL bounce_rise got rises=%0d edge=%0d want 1 at 6", rises, rise_edge);
    end
    checks++;
    if (btn_evt !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_evt got %b want 0001", btn_evt);
    end
  endtask

  task automatic test_collision();
    do_reset();
    irq_en  = 4'b0010;
    btn_raw = 4'b0010;
    repeat (5) @(negedge clk);
    evt_clr = 4'b0010;
    @(negedge clk);
    checks++;
    if (btn_evt !== 4'b0010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL collide_set got evt=%b irq=%b want 0010 1", btn_evt, irq);
    end
    @(negedge clk);
    evt_clr = '0;
    checks++;
    if (btn_evt !== 4'b0000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL collide_clr got evt=%b irq=%b want 0000 0", btn_evt, irq);
    end
  endtask

  task automatic test_led_modes();
    logic [CH-1:0] smp[20];
    logic [CH-1:0] lvl_before[20];
    int ones0, ones1, ones2, bad_blink, bad_follow;
    do_reset();
    led_val  = 4'b1111;
    led_mode = 8'b11_10_01_00;
    led_duty = 3'd3;
    btn_raw  = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      lvl_before[k] = btn_lvl;
      @(negedge clk);
      smp[k] = led_out;
    end
    ones0 = 0; ones1 = 0; ones2 = 0; bad_blink = 0; bad_follow = 0;
    for (int k = 2; k < 18; k++) begin
      ones0 += int'(smp[k][0]);
      ones1 += int'(smp[k][1]);
      ones2 += int'(smp[k][2]);
      if (smp[k][1] == smp[k+2 < 20 ? k : k][1] && smp[k][1] == smp[(k+4) % 20][1] && k + 4 < 20) bad_blink++;
    end
    for (int k = 0; k < 20; k++)
      if (smp[k][3] !== lvl_before[k][3]) bad_follow++;
    checks++;
    if (ones0 !== 16) begin
      errors++;
      $display("FAIL led_static got %0d ones want 16", ones0);
    end
    checks++;
    if (ones1 !== 8 || bad_blink !== 0) begin
      errors++;
      $display("FAIL led_blink got ones=%0d bad_halfperiod=%0d want 8 0", ones1, bad_blink);
    end
    checks++;
    if (ones2 !== 6) begin
      errors++;
      $display("FAIL led_pwm3 got %0d ones want 6", ones2);
    end
    checks++;
    if (bad_follow !== 0 || smp[19][3] !== 1'b1) begin
      errors++;
      $display("FAIL led_follow got mism=%0d last=%b want 0 1", bad_follow, smp[19][3]);
    end
  endtask

  task automatic test_pwm_bounds();
    int ones;
    do_reset();
    led_val  = 4'b1111;
    led_mode = 8'b10_10_10_10;
    led_duty = 3'd0;
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ones += int'(led_out != 4'b0000);
    end
    checks++;
    if (ones !== 0) begin
      errors++;
      $display("FAIL pwm_duty0 got %0d high cycles want 0", ones);
    end
    led_duty = 3'd7;
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ones += int'(led_out[0]);
    end
    checks++;
    if (ones !== 14) begin
      errors++;
      $display("FAIL pwm_duty7 got %0d high of 16 want 14", ones);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    led_val = 4'b1111;
    btn_raw = 4'b0101;
    repeat (6) @(negedge clk);
    btn_raw = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (btn_evt !== 4'b0101 || led_out !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset got evt=%b led=%b want 0101 1111", btn_evt, led_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({btn_lvl, btn_evt, irq, led_out} !== '0) begin
      errors++;
      $display("FAIL async_reset got lvl=%b evt=%b irq=%b led=%b want all 0",
               btn_lvl, btn_evt, irq, led_out);
    end
    @(negedge clk);
    rst = 1'b0;
    led_val = '0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) begin
        checks++;
        if (btn_lvl !== 4'b0000 || btn_evt !== 4'b0000) begin
          errors++;
          $display("FAIL requal_edge5 got lvl=%b evt=%b want 0000 0000", btn_lvl, btn_evt);
        end
      end
    end
    checks++;
    if (btn_lvl !== 4'b1111 || btn_evt !== 4'b1111) begin
      errors++;
      $display("FAIL requal_edge6 got lvl=%b evt=%b want 1111 1111", btn_lvl, btn_evt);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] raw_r;
    do_reset();
    raw_r = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if (btn_lvl !== m_lvl || btn_evt !== m_evt || irq !== m_irq || led_out !== m_led) begin
        errors++;
        $display("FAIL random_cyc%0d got lvl=%b evt=%b irq=%b led=%b want %b %b %b %b",
                 k, btn_lvl, btn_evt, irq, led_out, m_lvl, m_evt, m_irq, m_led);
      end
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 6) == 0) raw_r[i] = ~raw_r[i];
      btn_raw = raw_r;
      for (int i = 0; i < CH; i++) evt_clr[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) irq_en = CH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) led_val = CH'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) led_mode = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) led_duty = PB'($urandom_range(0, 7));
    end
  endtask

  initial begin
    test_reset();
    test_debounce_timing(4'b0001);
    test_debounce_timing(4'b0000);
    test_bounce();
    test_collision();
    test_led_modes();
    test_pwm_bounds();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
